// File: rtl/jpeg_mm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jpeg_mm_pkg
//  Purpose  : Shared widths, vector types and lane-slice helpers for the
//             DCT matrix-multiply datapath.
//  Revision : 1.0  initial release
// ============================================================================
package jpeg_mm_pkg;

    localparam int FLOAT_W = 32;
    localparam int VEC_LEN = 8;
    localparam int VEC_W   = 256;

    typedef logic [31:0]  float_t;
    typedef logic [255:0] vec_t;

    // Lane 0 occupies the top 32 bits; lane k sits at [255-32k -: 32].
    function automatic int lane_msb(input logic [2:0] k);
        return VEC_W - 1 - FLOAT_W * int'(k);
    endfunction

    function automatic float_t get_lane(input vec_t v, input logic [2:0] k);
        return v[lane_msb(k) -: FLOAT_W];
    endfunction

    function automatic vec_t set_lane(input vec_t v, input logic [2:0] k, input float_t f);
        vec_t r;
        r = v;
        r[lane_msb(k) -: FLOAT_W] = f;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : row_fifo
//  Purpose  : Small row buffer carrying a 256-bit vector plus a 3-bit row tag,
//             head presented straight from storage registers.
//  Revision : 1.0  initial release
// ============================================================================
module row_fifo
    import jpeg_mm_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  vec_t       push_data,
    input  logic [2:0] push_tag,
    input  logic       pop,
    output vec_t       head_data,
    output logic [2:0] head_tag,
    output logic       full,
    output logic       empty
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ADDR_W:0] c_FULL_CNT = (c_ADDR_W + 1)'(DEPTH);

    vec_t                r_data [DEPTH];
    logic [2:0]          r_tag  [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;

    logic w_pop;
    logic w_push;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_FULL_CNT);

    // A push into a full buffer is taken only when the head leaves the same cycle.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    assign head_data = r_data[r_rd_ptr];
    assign head_tag  = r_tag[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= push_data;
                r_tag[r_wr_ptr]  <= push_tag;
                r_wr_ptr         <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            r_count <= r_count + (c_ADDR_W + 1)'(w_push) - (c_ADDR_W + 1)'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_row_packer.sv
`default_nettype none
// ============================================================================
//  Module   : result_row_packer
//  Purpose  : Packs eight consecutive dot-product results into a row vector,
//             buffers finished rows and tracks row position in an 8x8 block.
//  Revision : 1.0  initial release
// ============================================================================
module result_row_packer
    import jpeg_mm_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  float_t     data_in,
    input  logic       validin,
    output vec_t       row_out,
    output logic       validout,
    input  logic       readyin,
    output logic [2:0] row_index,
    output logic       block_done,
    output logic       overflow
);

    localparam int c_LANE_W = $clog2(VEC_LEN);
    localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(VEC_LEN - 1);
    localparam logic [2:0] c_LAST_ROW = 3'd7;

    vec_t                r_asm;
    logic [c_LANE_W-1:0] r_lane;
    logic [2:0]          r_row_cnt;
    logic                r_overflow;
    logic                r_block_done;

    logic w_commit;
    logic w_pop;
    logic w_full;
    logic w_empty;
    vec_t w_row;

    assign w_commit = validin && (r_lane == c_LAST_LANE);
    // Lane 7 bypasses the assembly register so the row commits on its own edge.
    assign w_row    = set_lane(r_asm, 3'(c_LAST_LANE), data_in);
    assign validout = !w_empty;
    assign w_pop    = validout && readyin;

    row_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_commit),
        .push_data (w_row),
        .push_tag  (r_row_cnt),
        .pop       (w_pop),
        .head_data (row_out),
        .head_tag  (row_index),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_asm        <= '0;
            r_lane       <= '0;
            r_row_cnt    <= '0;
            r_overflow   <= 1'b0;
            r_block_done <= 1'b0;
        end else begin
            if (validin) begin
                r_asm  <= set_lane(r_asm, 3'(r_lane), data_in);
                r_lane <= r_lane + c_LANE_W'(1);
            end
            // Row count advances even on a dropped row to stay block-aligned.
            if (w_commit) begin
                r_row_cnt <= r_row_cnt + 3'd1;
                if (w_full && !w_pop) begin
                    r_overflow <= 1'b1;
                end
            end
            r_block_done <= w_pop && (row_index == c_LAST_ROW);
        end
    end

    assign overflow   = r_overflow;
    assign block_done = r_block_done;

endmodule
`default_nettype wire

// File: tb/tb_result_row_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_row_packer
//  Purpose  : Self-checking bench for result_row_packer with a cycle model,
//             a row scoreboard and a vector table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_result_row_packer;
    import jpeg_mm_pkg::*;

    localparam int DEPTH = 2;
    localparam vec_t ROW_1TO8 =
        256'h3f800000_40000000_40400000_40800000_40a00000_40c00000_40e00000_41000000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       validin = 1'b0;
    logic       readyin = 1'b0;
    float_t     data_in = '0;
    vec_t       row_out;
    logic       validout;
    logic [2:0] row_index;
    logic       block_done;
    logic       overflow;

    result_row_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .validin    (validin),
        .row_out    (row_out),
        .validout   (validout),
        .readyin    (readyin),
        .row_index  (row_index),
        .block_done (block_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        vec_t       row;
        logic [2:0] tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        float_t     base;
        float_t     step;
        int         gap;
        logic [2:0] exp_idx;
        logic       exp_ovf;
    } vec_rec_t;
    vec_rec_t tab[8];

    float_t ones_to_eight[8] = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000};

    bit         mon_en = 1'b0;
    logic [2:0] m_lane = '0;
    logic [2:0] m_row = '0;
    float_t     m_asm[8];
    bit         m_ovf = 1'b0;
    bit         m_bd = 1'b0;
    int         tx_cnt = 0;
    int         bd_cnt = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic vec_t mkrow(input float_t base, input float_t step);
        vec_t v;
        for (int k = 0; k < 8; k++) v[255-32*k -: 32] = base + step * 32'(k);
        return v;
    endfunction

    // Reference model and scoreboard, evaluated on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        bit   pop;
        vec_t r;
        if (mon_en) begin
            chk("validout", 256'(validout), 256'(sb.size() != 0));
            chk("block_done", 256'(block_done), 256'(m_bd));
            chk("overflow", 256'(overflow), 256'(m_ovf));
            if (block_done) bd_cnt++;
        end
        if (!rst_n) begin
            sb.delete();
            m_lane = '0;
            m_row  = '0;
            m_ovf  = 1'b0;
            m_bd   = 1'b0;
        end else begin
            pop  = (sb.size() != 0) && readyin;
            m_bd = 1'b0;
            if (pop) begin
                e = sb.pop_front();
                tx_cnt++;
                chk("row_out", row_out, e.row);
                chk("row_index", 256'(row_index), 256'(e.tag));
                m_bd = (e.tag == 3'd7);
            end
            if (validin) begin
                m_asm[m_lane] = data_in;
                if (m_lane == 3'd7) begin
                    for (int k = 0; k < 8; k++) r[255-32*k -: 32] = m_asm[k];
                    if (sb.size() < DEPTH) sb.push_back('{r, m_row});
                    else m_ovf = 1'b1;
                    m_row = m_row + 3'd1;
                end
                m_lane = m_lane + 3'd1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input float_t d, input int gap);
        validin = 1'b1;
        data_in = d;
        tick();
        validin = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_row(input float_t base, input float_t step, input int gap);
        for (int k = 0; k < 8; k++) send(base + step * 32'(k), (k == 7) ? 0 : gap);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        validin = 1'b0;
        readyin = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int t0;
        int b0;
        tab[0] = '{32'h3f800000, 32'h00800000, 0, 3'd0, 1'b0};
        tab[1] = '{32'h7fc00000, 32'h00000001, 1, 3'd1, 1'b0};
        tab[2] = '{32'h00000001, 32'h00000002, 0, 3'd2, 1'b0};
        tab[3] = '{32'hffffff00, 32'h00000040, 2, 3'd3, 1'b0};
        tab[4] = '{32'h80000000, 32'h11111111, 0, 3'd4, 1'b0};
        tab[5] = '{32'hc2c80000, 32'hfff00000, 1, 3'd5, 1'b0};
        tab[6] = '{32'h00000000, 32'h00000000, 0, 3'd6, 1'b0};
        tab[7] = '{32'h12345678, 32'h9abcdef1, 2, 3'd7, 1'b0};

        // Reset state
        do_reset();
        mon_en = 1'b1;
        chk("reset_validout", 256'(validout), 256'd0);
        chk("reset_block_done", 256'(block_done), 256'd0);
        chk("reset_overflow", 256'(overflow), 256'd0);
        chk("reset_row_index", 256'(row_index), 256'd0);
        chk("reset_row_out", row_out, 256'd0);

        // Back-to-back row
        readyin = 1'b1;
        for (int k = 0; k < 8; k++) send(ones_to_eight[k], 0);
        chk("b2b_validout", 256'(validout), 256'd1);
        chk("b2b_row_out", row_out, ROW_1TO8);
        chk("b2b_row_index", 256'(row_index), 256'd0);
        tick();
        chk("b2b_drop_valid", 256'(validout), 256'd0);

        // Gapped row, one on / three off
        for (int k = 0; k < 8; k++) begin
            send(ones_to_eight[k], (k == 7) ? 0 : 3);
            if (k < 7) chk("gap_no_early_valid", 256'(validout), 256'd0);
        end
        chk("gap_validout", 256'(validout), 256'd1);
        chk("gap_row_out", row_out, ROW_1TO8);
        chk("gap_row_index", 256'(row_index), 256'd1);
        tick();

        // Overflow: third row dropped with downstream stalled
        do_reset();
        for (int i = 0; i < 3; i++) send_row(32'h3f800000, 32'h0, 0);
        chk("ovf_set", 256'(overflow), 256'd1);
        chk("ovf_head_index", 256'(row_index), 256'd0);
        t0 = tx_cnt;
        readyin = 1'b1;
        repeat (4) tick();
        chk("ovf_drained", 256'(tx_cnt - t0), 256'd2);
        send_row(32'h40000000, 32'h0, 0);
        chk("ovf_next_index", 256'(row_index), 256'd3);
        tick();
        chk("ovf_sticky", 256'(overflow), 256'd1);

        // Full FIFO with pop coinciding with commit
        do_reset();
        send_row(32'h3f800000, 32'h1, 0);
        send_row(32'h40000000, 32'h1, 0);
        for (int k = 0; k < 7; k++) send(32'h40400000 + 32'(k), 0);
        readyin = 1'b1;
        send(32'h40400007, 0);
        readyin = 1'b0;
        chk("full_pop_no_ovf", 256'(overflow), 256'd0);
        repeat (3) tick();
        chk("full_pop_valid", 256'(validout), 256'd1);
        chk("full_pop_head_idx", 256'(row_index), 256'd1);
        chk("full_pop_head_row", row_out, mkrow(32'h40000000, 32'h1));
        t0 = tx_cnt;
        readyin = 1'b1;
        repeat (4) tick();
        chk("full_pop_two_left", 256'(tx_cnt - t0), 256'd2);
        chk("full_pop_empty", 256'(validout), 256'd0);

        // Full block of 64 results from the vector table
        do_reset();
        readyin = 1'b1;
        b0 = bd_cnt;
        for (int i = 0; i < 8; i++) begin
            send_row(tab[i].base, tab[i].step, tab[i].gap);
            chk("tab_row_index", 256'(row_index), 256'(tab[i].exp_idx));
            chk("tab_row_out", row_out, mkrow(tab[i].base, tab[i].step));
            chk("tab_overflow", 256'(overflow), 256'(tab[i].exp_ovf));
        end
        repeat (3) tick();
        chk("block_done_once", 256'(bd_cnt - b0), 256'd1);
        send_row(32'h3f800000, 32'h0, 0);
        chk("block_wrap_index", 256'(row_index), 256'd0);
        repeat (3) tick();
        chk("block_done_still_once", 256'(bd_cnt - b0), 256'd1);

        // Reset mid-row with one row buffered
        do_reset();
        for (int k = 0; k < 8; k++) send(ones_to_eight[k], 0);
        for (int k = 0; k < 5; k++) send(32'hdeadbeef, 0);
        rst_n = 1'b0;
        tick();
        chk("midrst_validout", 256'(validout), 256'd0);
        rst_n = 1'b1;
        readyin = 1'b1;
        t0 = tx_cnt;
        send_row(32'h11111111, 32'h01010101, 0);
        chk("midrst_row_index", 256'(row_index), 256'd0);
        chk("midrst_row_out", row_out, mkrow(32'h11111111, 32'h01010101));
        repeat (4) tick();
        chk("midrst_one_row", 256'(tx_cnt - t0), 256'd1);

        chk("scoreboard_drained", 256'(sb.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
